mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 15, SHALL set the word address width (depth = 2**ADDR_WIDTH).
REQ-002 Parameter DATA_WIDTH, default 16, SHALL set the word width.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 req_valid  input  1  SHALL flag a valid request.
REQ-006 req_ready  output  1  SHALL flag that a request is accepted this cycle.
REQ-007 req_write  input  1  SHALL select write (1) or read (0).
REQ-008 req_address  input  ADDR_WIDTH  SHALL be the word address.
REQ-009 req_data  input  DATA_WIDTH  SHALL be the write data.
REQ-010 rsp_valid  output  1  SHALL flag valid response data.
REQ-011 rsp_ready  input  1  SHALL flag that the consumer takes the response.
REQ-012 rsp_data  output  DATA_WIDTH  SHALL be the response data.
REQ-013 clear  input  1  SHALL request a zero-fill of the whole array.
REQ-014 busy  output  1  SHALL be high while a clear sweep runs.

Function
REQ-015 The FSM SHALL have states IDLE, RESP and CLEAR.
REQ-016 req_ready SHALL equal (state == IDLE && !clear), combinationally.
REQ-017 A request SHALL be accepted on any edge where req_valid && req_ready.
REQ-018 An accepted write SHALL store req_data at req_address on the accepting edge; the FSM stays in IDLE and no response is issued.
REQ-019 An accepted read SHALL register array[req_address] into rsp_data on the accepting edge, set rsp_valid and move to RESP: one-cycle latency.
REQ-020 In RESP, rsp_valid and rsp_data SHALL hold stable until an edge with rsp_ready high, after which rsp_valid = 0 and state = IDLE.
REQ-021 Maximum read throughput SHALL be one read per two cycles; no request is accepted in RESP.
REQ-022 clear high in IDLE SHALL take priority over req_valid on the same edge: enter CLEAR, sweep counter = 0, busy = 1.
REQ-023 clear outside IDLE SHALL be ignored; it is not latched.
REQ-024 In CLEAR, each edge SHALL write 0 at the counter address and increment the counter.
REQ-025 After the write at address 2**ADDR_WIDTH-1, the FSM SHALL return to IDLE with busy = 0. A sweep takes exactly 2**ADDR_WIDTH cycles, and the counter does not wrap into a second pass.
REQ-026 rsp_data SHALL keep its last value when rsp_valid is low.

Reset
REQ-027 While reset is high, the block SHALL set state = IDLE, rsp_valid = 0, rsp_data = 0, busy = 0 and sweep counter = 0.
REQ-028 Reset SHALL NOT initialise the array; contents are undefined after power-up.
REQ-029 Reset during CLEAR SHALL abort the sweep; already-zeroed words stay zero.
REQ-030 Reset during RESP SHALL drop the pending response.

Configuration
REQ-031 Macro MEM_RESPONDER_WRITE_ACK_EN defined: an accepted write SHALL also set rsp_valid, load rsp_data with req_data and enter RESP, with the same handshake as reads.
REQ-032 Macro undefined: writes SHALL produce no response (REQ-018).

Structure
REQ-033 Package mem_responder_pkg SHALL hold the state enum (IDLE, RESP, CLEAR) and the default ADDR_WIDTH, DATA_WIDTH and DEPTH constants.
REQ-034 Storage SHALL be a sub-module ram32k_array: single port, synchronous write, registered read, ports clock, in, load, address, out.
REQ-035 The FSM and sweep counter SHALL sit in mem_responder; the sweep counter drives the array address and load during CLEAR.

Verification
REQ-036 Write 0xB555 to 0x01C0, then read 0x01C0 -> rsp_valid high the cycle after accept, rsp_data = 0xB555.
REQ-037 Read 0x01C0 with rsp_ready low for 3 cycles -> rsp_data stable at 0xB555, req_ready low throughout; IDLE one edge after rsp_ready rises.
REQ-038 Assert clear for one cycle -> busy high for exactly 32768 cycles; reads of 0x01C0 and 0x7FFF then return 0x0000.
REQ-039 clear and read request on the same edge -> CLEAR entered, request not accepted, req_ready low.
REQ-040 reset at sweep cycle 100 -> busy = 0 next cycle; a previously written 0x1234 at 0x0200 reads back unchanged.
REQ-041 With MEM_RESPONDER_WRITE_ACK_EN, write 0x00FF to 0x0003 -> rsp_valid the next cycle, rsp_data = 0x00FF; without the macro, rsp_valid stays 0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and default geometry for the mem_responder block.
package mem_responder_pkg;
  localparam int DEFAULT_ADDR_WIDTH = 15;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DEPTH      = 2 ** DEFAULT_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, RESP, CLEAR} state_t;
endpackage

// File: rtl/ram32k_array.sv
// Single-port storage: synchronous write, registered read (old data on a write edge).
// No reset on the array; contents are undefined until written.
module ram32k_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] out
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clock) begin
    if (load) mem[address] <= in;
    out <= mem[address];
  end

endmodule

// File: rtl/mem_responder.sv
// Request/response front end over ram32k_array with a full zero-fill sweep; reads return one cycle after accept,
// one request per two cycles, response held until rsp_ready. MEM_RESPONDER_WRITE_ACK_EN makes writes respond too.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  clear,
  output logic                  busy
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_in;
  logic [DATA_WIDTH-1:0] ram_out;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  ram_load;
  logic                  from_ram;
  logic                  accept;

  assign req_ready = (state == IDLE) && !clear;
  assign accept    = req_valid && req_ready;

  // The array's read register is the response register for reads; data_q
  // holds the last response once the array output is free to move again.
  assign rsp_data = from_ram ? ram_out : data_q;

  always_comb begin
    ram_load = 1'b0;
    ram_addr = req_address;
    ram_in   = req_data;
    case (state)
      CLEAR: begin
        ram_load = !reset;
        ram_addr = sweep_cnt;
        ram_in   = '0;
      end
      RESP:    ram_addr = rd_addr_q;
      default: ram_load = !reset && accept && req_write;
    endcase
  end

  ram32k_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clock  (clock),
    .in     (ram_in),
    .load   (ram_load),
    .address(ram_addr),
    .out    (ram_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      sweep_cnt <= '0;
      rd_addr_q <= '0;
      data_q    <= '0;
      from_ram  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            state     <= CLEAR;
            busy      <= 1'b1;
            sweep_cnt <= '0;
          end else if (req_valid) begin
            if (!req_write) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              from_ram  <= 1'b1;
              rd_addr_q <= req_address;
            end
`ifdef MEM_RESPONDER_WRITE_ACK_EN
            else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              data_q    <= req_data;
            end
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            from_ram  <= 1'b0;
            if (from_ram) data_q <= ram_out;
          end
        end
        CLEAR: begin
          if (sweep_cnt == '1) begin
            state     <= IDLE;
            busy      <= 1'b0;
            sweep_cnt <= '0;
          end else begin
            sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
